// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding, BCD digit limit and result-width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2,
        FIN  = 2'd3
    } bcd_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Smallest BIN_W with 2^BIN_W > 10^digits - 1.
    function automatic int min_bin_w(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return $clog2(v);
    endfunction

endpackage

// File: rtl/bcd_digit_valid.sv
// bcd_digit_valid: flags a nibble as a legal BCD digit (0..9).
module bcd_digit_valid
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic       valid_o
);

    assign valid_o = (digit_i <= BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_binary_serial.sv
// bcd_to_binary_serial: packed BCD to binary, one digit per clock, MS digit first,
// with per-digit validation and a start/busy/done handshake.
module bcd_to_binary_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic [2:0]            err_digit
);

    bcd_state_t          state_q, state_d;
    logic [BIN_W-1:0]    acc_q, acc_d, bin_q, bin_d, acc_mac;
    logic [4*DIGITS-1:0] opr_q, opr_d;
    logic [2:0]          cnt_q, cnt_d, errd_q, errd_d;
    logic                err_q, err_d;
    logic [3:0]          digit;
    logic                digit_ok;

    assign digit   = 4'(opr_q >> {cnt_q, 2'b00});
    assign acc_mac = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

    bcd_digit_valid u_valid (
        .digit_i (digit),
        .valid_o (digit_ok)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opr_d   = opr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        errd_d  = errd_q;
        case (state_q)
            IDLE: if (start) begin
                opr_d   = bcd_in;
                acc_d   = '0;
                cnt_d   = 3'(DIGITS - 1);
                state_d = LOAD;
            end
            LOAD: state_d = CONV;
            CONV: if (!digit_ok) begin
                err_d   = 1'b1;
                errd_d  = cnt_q;
                bin_d   = '0;
                state_d = FIN;
            end else begin
                acc_d = acc_mac;
                // Results are latched on entry to FIN so they are valid alongside done.
                if (cnt_q == 3'd0) begin
                    bin_d   = acc_mac;
                    err_d   = 1'b0;
                    errd_d  = 3'd0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            opr_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            errd_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            errd_q  <= errd_d;
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == CONV);
    assign done      = (state_q == FIN);
    assign bin_out   = bin_q;
    assign err       = err_q;
    assign err_digit = errd_q;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// tb_bcd_to_binary_serial: directed vectors with hand-computed results for the serial BCD converter.
module tb_bcd_to_binary_serial;

    logic        CLOCK_50;
    logic        resetn;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;
    logic [2:0]  err_digit;

    int vectors;
    int miscompares;
    int cyc;
    logic saw_done;

    bcd_to_binary_serial #(.DIGITS(4), .BIN_W(14)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .err       (err),
        .err_digit (err_digit)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts cycles from the start cycle (cycle 0) up to the done cycle, bounded.
    task automatic wait_done();
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] v, input int lat,
                       input int eb, input logic ee, input int ed);
        bcd_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 1;
        wait_done();
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " bin_out"}, 32'(bin_out), 32'(eb));
        chk({tag, " err"}, 32'(err), 32'(ee));
        chk({tag, " err_digit"}, 32'(err_digit), 32'(ed));
        tick();
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        start       = 1'b0;
        bcd_in      = 16'h0000;
        #3;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bin_out", 32'(bin_out), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset err_digit", 32'(err_digit), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // 1234 with busy observed through LOAD and CONV
        bcd_in = 16'h1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bcd_in = 16'h0000;
        chk("1234 busy LOAD", 32'(busy), 32'd1);
        chk("1234 done early", 32'(done), 32'd0);
        cyc = 1;
        repeat (4) begin
            tick();
            cyc++;
            chk("1234 busy CONV", 32'(busy), 32'd1);
        end
        wait_done();
        chk("1234 latency", 32'(cyc), 32'd6);
        chk("1234 bin_out", 32'(bin_out), 32'd1234);
        chk("1234 err", 32'(err), 32'd0);
        chk("1234 busy at done", 32'(busy), 32'd0);
        tick();
        chk("1234 done pulse width", 32'(done), 32'd0);

        // 9999 then 0000 with start held high
        bcd_in = 16'h9999;
        start  = 1'b1;
        tick();
        cyc = 1;
        wait_done();
        chk("9999 latency", 32'(cyc), 32'd6);
        chk("9999 bin_out", 32'(bin_out), 32'd9999);
        bcd_in = 16'h0000;
        tick();
        cyc = 1;
        wait_done();
        start = 1'b0;
        chk("b2b done spacing", 32'(cyc), 32'd7);
        chk("0000 bin_out", 32'(bin_out), 32'd0);
        chk("0000 err", 32'(err), 32'd0);
        tick();

        run("12A4", 16'h12A4, 5, 0, 1'b1, 1);
        run("0042", 16'h0042, 6, 42, 1'b0, 0);

        // start re-pulsed mid-conversion with a new operand
        bcd_in = 16'h0567;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        start  = 1'b1;
        bcd_in = 16'h8888;
        tick();
        start  = 1'b0;
        cyc    = 3;
        wait_done();
        chk("0567 latency", 32'(cyc), 32'd6);
        chk("0567 bin_out", 32'(bin_out), 32'd567);
        saw_done = 1'b0;
        repeat (10) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        chk("0567 no second conversion", 32'(saw_done), 32'd0);

        // asynchronous reset mid-cycle during CONV
        bcd_in = 16'h4321;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        chk("4321 busy before reset", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        chk("async reset bin_out", 32'(bin_out), 32'd0);
        chk("async reset err", 32'(err), 32'd0);
        chk("async reset err_digit", 32'(err_digit), 32'd0);
        tick();
        resetn = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            tick();
            saw_done = saw_done | done;
        end
        chk("aborted no done", 32'(saw_done), 32'd0);
        run("0007", 16'h0007, 6, 7, 1'b0, 0);

        run("F000", 16'hF000, 3, 0, 1'b1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
